// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    localparam logic [7:0]  LOADER_MAGIC = 8'hA5;
    localparam int unsigned LEN_W        = 16;
    localparam int unsigned WORD_W       = 32;

    function automatic logic is_magic(input logic [7:0] b);
        return b == LOADER_MAGIC;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs bytes little-endian into 32-bit words; word_valid pulses the cycle after
// the fourth byte is accepted, holding the assembled word until the next one.
module byte_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              last_byte_c,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data
);

    logic [1:0]        idx_q, idx_d;
    logic [23:0]       acc_q, acc_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              word_valid_q, word_valid_d;

    // Byte lanes 0..2 accumulate; lane 3 completes the word.
    always_comb begin
        idx_d        = idx_q;
        acc_d        = acc_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clr) begin
            idx_d = '0;
            acc_d = '0;
        end else if (byte_valid) begin
            case (idx_q)
                2'd0:    acc_d[7:0]   = byte_data;
                2'd1:    acc_d[15:8]  = byte_data;
                2'd2:    acc_d[23:16] = byte_data;
                default: begin
                    word_d       = {byte_data, acc_q};
                    word_valid_d = 1'b1;
                    acc_d        = '0;
                end
            endcase
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            acc_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign last_byte_c = (idx_q == 2'd3);
    assign word_valid  = word_valid_q;
    assign word_data   = word_q;

endmodule

// File: rtl/prog_loader.sv
// Framed program loader: MAGIC, LEN_LO, LEN_HI, 4*N data bytes [, CSUM] -> i_mem.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned ADDR_W     = $clog2(IMEM_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [LEN_W-1:0]  words_loaded
);

    loader_state_t     state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  len_full;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic              core_rst_q, core_rst_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
    logic              in_ready_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              pk_clr;
    logic              pk_byte_valid;
    logic              pk_last_c;
    logic              pk_word_valid;
    logic [WORD_W-1:0] pk_word;

    byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (pk_clr),
        .byte_valid  (pk_byte_valid),
        .byte_data   (in_data),
        .last_byte_c (pk_last_c),
        .word_valid  (pk_word_valid),
        .word_data   (pk_word)
    );

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        len_full      = {in_data, len_q[7:0]};
        addr_d        = addr_q;
        words_d       = words_q;
        pk_clr        = 1'b0;
        pk_byte_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d        = csum_q;
`endif

        // Address advances after each write but saturates at the last word.
        if (pk_word_valid) begin
            words_d = words_q + LEN_W'(1);
            if (addr_q != ADDR_W'(IMEM_WORDS - 1)) begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (in_valid && is_magic(in_data)) begin
                    state_d = ST_LEN0;
                    pk_clr  = 1'b1;
                    words_d = '0;
                    addr_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_LEN0: begin
                if (in_valid) begin
                    len_d[7:0] = in_data;
                    state_d    = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (in_valid) begin
                    len_d = len_full;
                    if (len_full == '0 || 32'(len_full) > IMEM_WORDS) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (in_valid) begin
                    pk_byte_valid = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ in_data;
`endif
                    // words_q already counts every earlier word by the time the next 4th byte lands.
                    if (pk_last_c && (words_q + LEN_W'(1) == len_q)) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (in_valid) begin
                    state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Status levels follow a settled DONE/ERR state, so the core is released one
        // cycle after DONE is entered and the final write has already gone out.
        core_rst_d  = !(state_q == ST_DONE && state_d == ST_DONE);
        load_done_d =  (state_q == ST_DONE && state_d == ST_DONE);
        load_err_d  =  (state_q == ST_ERR  && state_d == ST_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            addr_q      <= '0;
            words_q     <= '0;
            core_rst_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            words_q     <= words_d;
            core_rst_q  <= core_rst_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            in_ready_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_we      = pk_word_valid;
    assign imem_addr    = addr_q;
    assign imem_wdata   = pk_word;
    assign core_rst     = core_rst_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a frame-level expectation model.
module tb_prog_loader;

    localparam int IMEM_WORDS = 256;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        load_done;
    logic        load_err;
    logic [15:0] words_loaded;

    prog_loader #(.IMEM_WORDS(IMEM_WORDS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;
    int we_count = 0;
    logic [7:0]  last_we_addr = 8'h00;
    logic        prev_we = 1'b0;
    logic        prev_core_rst = 1'b1;
    logic [31:0] mem [0:IMEM_WORDS-1];

    logic [7:0]  tx_q[$];
    logic [31:0] wq[$];
    logic [7:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every cycle: writes must match the expected queue, status levels must be coherent.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_high", in_ready, 1'b1);
            check("done_vs_core_rst", load_done, !core_rst);
            check("done_err_exclusive", load_done & load_err, 1'b0);
            if (imem_we) begin
                we_count++;
                last_we_addr = imem_addr;
                mem[imem_addr] = imem_wdata;
                check("we_core_held", core_rst, 1'b1);
                check("we_expected", exp_addr_q.size() != 0, 1'b1);
                if (exp_addr_q.size() != 0) begin
                    check("we_addr", imem_addr, exp_addr_q.pop_front());
                    check("we_data", imem_wdata, exp_data_q.pop_front());
                end
            end
            if (prev_core_rst && !core_rst) begin
                check("release_after_last_we", prev_we, 1'b1);
                check("release_queue_empty", exp_addr_q.size(), 0);
            end
        end
        prev_we = imem_we;
        prev_core_rst = core_rst;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_all(input int max_gap);
        logic [7:0] b;
        while (tx_q.size() != 0) begin
            b = tx_q.pop_front();
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            send_byte(b);
        end
    endtask

    // Builds a frame from wq and queues the writes it must produce.
    task automatic make_frame(input bit bad_cs, output logic [7:0] cs_out);
        logic [7:0] cs;
        logic [7:0] b;
        int n;
        cs = 8'h00;
        n = wq.size();
        tx_q.push_back(8'hA5);
        tx_q.push_back(n[7:0]);
        tx_q.push_back(n[15:8]);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = wq[i][8*k +: 8];
                cs = cs ^ b;
                tx_q.push_back(b);
            end
            exp_addr_q.push_back(i[7:0]);
            exp_data_q.push_back(wq[i]);
        end
`ifdef LOADER_CHECKSUM_EN
        tx_q.push_back(cs ^ {7'b0, bad_cs});
`endif
        cs_out = cs;
    endtask

    function automatic bit bad_cs_rejects(input bit bad_cs);
`ifdef LOADER_CHECKSUM_EN
        return bad_cs;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_status(input string name, input bit exp_done, input bit exp_err,
                                input int exp_words, input int we_base, input int exp_we);
        idle(6);
        check({name, "_load_done"}, load_done, exp_done);
        check({name, "_load_err"}, load_err, exp_err);
        check({name, "_core_rst"}, core_rst, !exp_done);
        check({name, "_words_loaded"}, words_loaded, exp_words[15:0]);
        check({name, "_we_pulses"}, we_count - we_base, exp_we);
        check({name, "_writes_pending"}, exp_addr_q.size(), 0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_in_ready"}, in_ready, 1'b1);
        check({name, "_imem_we"}, imem_we, 1'b0);
        check({name, "_imem_addr"}, imem_addr, 8'h00);
        check({name, "_imem_wdata"}, imem_wdata, 32'h0);
        check({name, "_core_rst"}, core_rst, 1'b1);
        check({name, "_load_done"}, load_done, 1'b0);
        check({name, "_load_err"}, load_err, 1'b0);
        check({name, "_words_loaded"}, words_loaded, 16'h0);
    endtask

    initial begin
        logic [7:0] cs;
        int base;
        bit rej;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #12;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Garbage before the first frame is discarded.
        tx_q = '{8'h00, 8'hFF, 8'h5A};
        wq = '{32'hDEADBEEF, 32'h0BADF00D};
        make_frame(1'b0, cs);
        base = we_count;
        send_all(0);
        check_status("garbage_first", 1'b1, 1'b0, 2, base, 2);
        check("garbage_mem1", mem[1], 32'h0BADF00D);

        // Non-magic bytes in DONE are ignored.
        tx_q = '{8'h00, 8'hFF, 8'h5A, 8'h13};
        base = we_count;
        send_all(0);
        check_status("done_ignore", 1'b1, 1'b0, 2, base, 0);

        // Two-word program, reload from DONE.
        wq = '{32'h00100513, 32'h00200593};
        make_frame(1'b0, cs);
        check("model_csum", cs, 8'hB0);
        check("model_bytes", {tx_q[3], tx_q[4], tx_q[5], tx_q[6]}, 32'h13051000);
        base = we_count;
        send_all(0);
        check_status("two_word", 1'b1, 1'b0, 2, base, 2);
        check("two_word_mem0", mem[0], 32'h00100513);
        check("two_word_mem1", mem[1], 32'h00200593);

        // Corrupted checksum, then a good frame.
        wq = '{32'h00100513, 32'h00200593};
        make_frame(1'b1, cs);
        rej = bad_cs_rejects(1'b1);
        base = we_count;
        send_all(0);
        check_status("bad_csum", !rej, rej, 2, base, 2);
        wq = '{32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0};
        make_frame(1'b0, cs);
        base = we_count;
        send_all(0);
        check_status("after_bad", 1'b1, 1'b0, 3, base, 3);

        // Length boundaries.
        tx_q = '{8'hA5, 8'h00, 8'h00};
        base = we_count;
        send_all(0);
        check_status("len_zero", 1'b0, 1'b1, 0, base, 0);
        tx_q = '{8'hA5, 8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        base = we_count;
        send_all(0);
        check_status("len_over", 1'b0, 1'b1, 0, base, 0);
        wq.delete();
        for (int i = 0; i < IMEM_WORDS; i++) wq.push_back((i * 32'h01000193) ^ 32'h5A5A0000);
        make_frame(1'b0, cs);
        base = we_count;
        send_all(0);
        check_status("len_max", 1'b1, 1'b0, IMEM_WORDS, base, IMEM_WORDS);
        check("len_max_last_addr", last_we_addr, 8'hFF);
        check("len_max_mem255", mem[255], (32'd255 * 32'h01000193) ^ 32'h5A5A0000);

        // Reset in the middle of DATA discards the partial word.
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05};
        send_all(0);
        rst_n = 1'b0;
        #2;
        check_reset_values("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        wq = '{32'h11223344, 32'h55667788};
        make_frame(1'b0, cs);
        base = we_count;
        send_all(0);
        check_status("post_reset", 1'b1, 1'b0, 2, base, 2);
        check("post_reset_mem0", mem[0], 32'h11223344);

        // Small program streamed with random valid gaps.
        wq = '{32'h00000093, 32'h00000113, 32'h00500193, 32'h00208093,
               32'h00110113, 32'hFFF18193, 32'hFE019CE3, 32'h0000006F};
        make_frame(1'b0, cs);
        base = we_count;
        send_all(3);
        check_status("gappy", 1'b1, 1'b0, 8, base, 8);
        check("gappy_mem7", mem[7], 32'h0000006F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
